aes128_inv_single_round: RTL and testbench

//  One AES-128 decryption (inverse) round over a 128-bit state, multi-cycle, start/done handshake.

---
 rtl/aes128_inv_single_round.sv | 138 +++++++++++++
 tb/tb_aes128_inv_single_round.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_single_round.sv
// One AES-128 inverse round: state_out = InvSubBytes(InvShiftRows(InvMixColumns(state_in ^ round_key))).
// Iterative: four cycles of column-serial InvMixColumns, then four cycles of row-serial InvShiftRows+InvSubBytes.
module aes128_inv_single_round (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         start,
  output logic [127:0] state_out,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, MIX, SUB} state_t;

  state_t       fsm_q;
  logic [1:0]   col_q;
  logic [1:0]   row_q;
  logic [7:0]   work_q [16];
  logic [127:0] state_out_q;
  logic         done_q;
  logic         busy_q;

  logic [7:0]   mix_in  [4];
  logic [7:0]   mix_out [4];
  logic [7:0]   sub_in  [4];
  logic [7:0]   sub_out [4];
  logic [127:0] result_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = product of x^(2^k), k=1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] p;
    sq = x;
    p  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  // Inverse affine map (bit i = b[i+2]^b[i+5]^b[i+7]^0x05) followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] inv_mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
    return gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
  endfunction

  // Lane gi handles row gi of the active column and byte gi of the active row.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] GI2 = 2'(gi);
      assign mix_in[gi]  = work_q[{GI2, col_q}];
      assign mix_out[gi] = inv_mix_byte(mix_in[gi], mix_in[(gi + 1) % 4],
                                        mix_in[(gi + 2) % 4], mix_in[(gi + 3) % 4]);
      assign sub_in[gi]  = work_q[{row_q, GI2 - row_q}];
      assign sub_out[gi] = inv_sbox(sub_in[gi]);
    end
  endgenerate

  // Full result for the final load: rows 0..2 already in work_q, row 3 straight from the lanes.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_result
      if (gi < 12) begin : g_keep
        assign result_d[127 - 8*gi -: 8] = work_q[gi];
      end else begin : g_last
        assign result_d[127 - 8*gi -: 8] = sub_out[gi - 12];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      state_out_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 16; i++) work_q[i] <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++)
              work_q[i] <= state_in[127 - 8*i -: 8] ^ round_key[127 - 8*i -: 8];
            col_q  <= 2'd0;
            busy_q <= 1'b1;
            fsm_q  <= MIX;
          end
        end
        MIX: begin
          for (int i = 0; i < 4; i++) work_q[{2'(i), col_q}] <= mix_out[i];
          col_q <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            row_q <= 2'd0;
            fsm_q <= SUB;
          end
        end
        SUB: begin
          for (int i = 0; i < 4; i++) work_q[{row_q, 2'(i)}] <= sub_out[i];
          row_q <= row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_out_q <= result_d;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_out = state_out_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_inv_single_round.sv
// Directed bench for aes128_inv_single_round: hand-computed vectors plus encrypt-model round trips.
module tb_aes128_inv_single_round;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         start;
  logic [127:0] state_out;
  logic         done;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [127:0] last_out = '0;

  aes128_inv_single_round dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .round_key (round_key),
    .start     (start),
    .state_out (state_out),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    while (bb != 0) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    return s ^ 8'h63;
  endfunction

  // Forward round whose inverse is the DUT: MixColumns(ShiftRows(SubBytes(x))) ^ k.
  function automatic logic [127:0] enc(input logic [127:0] x, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) s[i] = sbox(x[127 - 8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) t[4*r + j] = s[4*r + (j + r) % 4];
    for (int c = 0; c < 4; c++) begin
      a0 = t[c]; a1 = t[c + 4]; a2 = t[c + 8]; a3 = t[c + 12];
      y[127 - 8*c -: 8]        = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
      y[127 - 8*(c + 4) -: 8]  = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
      y[127 - 8*(c + 8) -: 8]  = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
      y[127 - 8*(c + 12) -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
    end
    return y ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a start for one edge; returns #1 after that accept edge.
  task automatic kick(input logic [127:0] in, input logic [127:0] key);
    @(negedge clk);
    state_in  = in;
    round_key = key;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Scrambles inputs every cycle and checks state_out holds until done.
  task automatic wait_done(output logic [127:0] res, output int lat);
    lat = 0;
    res = '0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      lat++;
      state_in  = rnd128();
      round_key = rnd128();
      if (done) break;
      chk("hold", state_out, last_out);
    end
    if (!done) chk_int("done_timeout", 0, 1);
    res      = state_out;
    last_out = state_out;
  endtask

  logic [127:0] res, x, k, y, ky, z, kz;
  int lat;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    state_in  = '0;
    round_key = '0;
    #12;
    chk("rst_out", state_out, '0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    kick('0, '0);
    chk_int("busy_after_start", int'(busy), 1);
    wait_done(res, lat);
    chk("zero_vec", res, 128'h52525252_52525252_52525252_52525252);
    chk_int("zero_lat", lat, 8);
    chk_int("busy_at_done", int'(busy), 0);
    @(posedge clk);
    #1;
    chk_int("done_pulse", int'(done), 0);

    kick({16{8'h63}}, '0);
    wait_done(res, lat);
    chk("const63_vec", res, '0);

    kick({16{8'h7c}}, '0);
    wait_done(res, lat);
    chk("const7c_vec", res, {16{8'h01}});

    for (int v = 0; v < 50; v++) begin
      x = (v < 5) ? 128'h00112233445566778899aabbccddeeff : rnd128();
      k = (v < 5) ? 128'h0f0e0d0c0b0a09080706050403020100 : rnd128();
      kick(enc(x, k), k);
      wait_done(res, lat);
      chk($sformatf("roundtrip%0d", v), res, x);
      chk_int($sformatf("lat%0d", v), lat, 8);
    end

    // Second start at E3 must be ignored.
    x = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    k = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    y = 128'h11111111_22222222_33333333_44444444;
    ky = 128'hffeeddcc_bbaa9988_77665544_33221100;
    kick(enc(x, k), k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start     = 1'b1;
    state_in  = enc(y, ky);
    round_key = ky;
    @(posedge clk); #1;
    start = 1'b0;
    chk_int("busy_ignored_start", int'(busy), 1);
    wait_done(res, lat);
    chk("ignored_start_result", res, x);
    chk_int("ignored_start_lat", lat, 5);

    // Start in the done cycle is accepted.
    start     = 1'b1;
    state_in  = enc(y, ky);
    round_key = ky;
    @(posedge clk); #1;
    start = 1'b0;
    chk_int("b2b_busy", int'(busy), 1);
    chk_int("b2b_done_low", int'(done), 0);
    wait_done(res, lat);
    chk("b2b_result", res, y);
    chk_int("b2b_lat", lat, 8);

    // Asynchronous reset after E4 aborts the round.
    z  = 128'h0badc0de_12345678_9abcdef0_55aa55aa;
    kz = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    kick(enc(z, kz), kz);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("abort_out", state_out, '0);
    chk_int("abort_done", int'(done), 0);
    chk_int("abort_busy", int'(busy), 0);
    last_out = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      chk_int("no_done_after_abort", int'(done), 0);
    end
    kick(enc(z, kz), kz);
    wait_done(res, lat);
    chk("post_reset_result", res, z);
    chk_int("post_reset_lat", lat, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
